// File: rtl/mb_fetch_sched.sv
// mb_fetch_sched: raster-order macroblock fetch scheduler; per macroblock it pulses the fetch unit,
// reads WORDS_PER_MB words one request at a time, forwards each word, then waits for mb_done_i.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_start_i     pulse that starts a frame (only honoured while idle)
//   mem_req_o/gnt_i   single-outstanding read request handshake, mem_addr_o valid while req is high
//   mem_rdata_i/rvalid_i  read response
//   fetch_start_o     one-cycle pulse at the start of each macroblock
//   data_word_o/valid_o   registered read data towards the fetch unit
//   mb_done_i         macroblock consumed by intra
//   mb_x_o, mb_y_o    current macroblock coordinates
//   busy_o            high outside IDLE
//   frame_done_o      one-cycle pulse after the last macroblock
module mb_fetch_sched #(
    parameter int unsigned FRAME_MB_W   = 11,
    parameter int unsigned FRAME_MB_H   = 9,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned WORDS_PER_MB = 96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        fetch_start_o,
    output logic [31:0] data_word_o,
    output logic        data_valid_o,
    input  logic        mb_done_i,
    output logic [5:0]  mb_x_o,
    output logic [5:0]  mb_y_o,
    output logic        busy_o,
    output logic        frame_done_o
);
    typedef enum logic [2:0] {IDLE, START, REQ, WAIT_DATA, WAIT_MB, NEXT, DONE} state_t;
    localparam logic [5:0]  LAST_X    = 6'(FRAME_MB_W - 1);
    localparam logic [5:0]  LAST_Y    = 6'(FRAME_MB_H - 1);
    localparam logic [6:0]  LAST_WORD = 7'(WORDS_PER_MB - 1);
    localparam logic [31:0] MB_STRIDE = 32'(WORDS_PER_MB);
    state_t      state, state_n;
    logic [31:0] mb_base;
    logic [6:0]  word_cnt;
    logic        rd_accept, last_word, last_x, last_mb;
    // read data is only taken while a request is outstanding
    assign rd_accept     = state == WAIT_DATA && mem_rvalid_i;
    assign last_word     = word_cnt == LAST_WORD;
    assign last_x        = mb_x_o == LAST_X;
    assign last_mb       = last_x && mb_y_o == LAST_Y;
    assign mem_req_o     = state == REQ;
    assign mem_addr_o    = mb_base + {25'd0, word_cnt};
    assign fetch_start_o = state == START;
    assign busy_o        = state != IDLE;
    assign frame_done_o  = state == DONE;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = frame_start_i ? START : IDLE;
            START:     state_n = REQ;
            REQ:       state_n = mem_gnt_i ? WAIT_DATA : REQ;
            WAIT_DATA: state_n = mem_rvalid_i ? (last_word ? WAIT_MB : REQ) : WAIT_DATA;
            WAIT_MB:   state_n = mb_done_i ? NEXT : WAIT_MB;
            NEXT:      state_n = last_mb ? DONE : START;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mb_x_o       <= '0;
            mb_y_o       <= '0;
            mb_base      <= '0;
            word_cnt     <= '0;
            data_word_o  <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= rd_accept;
            if (rd_accept) data_word_o <= mem_rdata_i;
            if (state == IDLE && frame_start_i) begin
                mb_x_o  <= '0;
                mb_y_o  <= '0;
                mb_base <= BASE_ADDR;
            end
            if (state == START) word_cnt <= '0;
            if (rd_accept && !last_word) word_cnt <= word_cnt + 7'd1;
            // base address advances by accumulation and wraps naturally at 2^32
            if (state == NEXT && !last_mb) begin
                mb_x_o  <= last_x ? 6'd0 : mb_x_o + 6'd1;
                mb_y_o  <= last_x ? mb_y_o + 6'd1 : mb_y_o;
                mb_base <= mb_base + MB_STRIDE;
            end
        end
    end
endmodule

// File: tb/tb_mb_fetch_sched.sv
// tb_mb_fetch_sched: directed frames with randomized memory timing against a frame-level reference model
module tb_mb_fetch_sched;
    localparam int W = 2, H = 2, WPM = 96, TOTAL = W * H * WPM;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    logic        clk = 0, rst = 1, frame_start_i = 0;
    logic        mem_gnt_i = 0, mem_rvalid_i = 0, mb_done_i = 1;
    logic [31:0] mem_rdata_i = 0;
    logic        mem_req_o, fetch_start_o, data_valid_o, busy_o, frame_done_o;
    logic [31:0] mem_addr_o, data_word_o;
    logic [5:0]  mb_x_o, mb_y_o;
    int checks = 0, fails = 0;
    int req_idx = 0, dv_idx = 0, fs_idx = 0, fd_cnt = 0, cyc = 0, last_fs = 0, hold = 0;
    int gnt_max = 0, rv_max = 1, gnt_cnt = 0, rv_cnt = 0;
    bit spur = 0, md_mode = 0, fast = 1, pending = 0, held = 0, busy_chk = 0, prev_busy = 0;
    logic [31:0] paddr = 0, prev_addr = 0;

    mb_fetch_sched #(.FRAME_MB_W(W), .FRAME_MB_H(H), .BASE_ADDR(BASE), .WORDS_PER_MB(WPM)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .fetch_start_o(fetch_start_o), .data_word_o(data_word_o), .data_valid_o(data_valid_o),
        .mb_done_i(mb_done_i), .mb_x_o(mb_x_o), .mb_y_o(mb_y_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory responder plus frame-level reference model, all evaluated at the falling edge
    initial begin : model
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy_chk) begin
                chk("busy_fall", busy_o, 0);
                busy_chk = 0;
            end
            if (fetch_start_o) begin
                if (!prev_busy) begin
                    req_idx = 0; dv_idx = 0; fs_idx = 0; fd_cnt = 0;
                end
                chk("fs_x", mb_x_o, fs_idx % W);
                chk("fs_y", mb_y_o, fs_idx / W);
                chk("fs_before_data", dv_idx, fs_idx * WPM);
                if (fast && fs_idx > 0) chk("mb_cycles", cyc - last_fs, 195);
                last_fs = cyc;
                fs_idx++;
            end
            prev_busy = busy_o;
            if (frame_done_o) begin
                chk("done_busy", busy_o, 1);
                chk("done_words", dv_idx, TOTAL);
                if (fast) chk("done_lat", cyc - last_fs, 195);
                fd_cnt++;
                busy_chk = 1;
            end
            if (!md_mode) begin
                mb_done_i = 1;
                hold = 0;
            end else if (hold > 0) begin
                chk("hold_no_req", {mem_req_o, fetch_start_o}, 0);
                hold--;
                mb_done_i = hold == 0;
            end else mb_done_i = 1'($urandom_range(0, 1));
            if (data_valid_o) begin
                ea = BASE + dv_idx;
                chk("data_word", data_word_o, mem_word(ea));
                dv_idx++;
                if (md_mode && dv_idx % WPM == 0) begin
                    hold = 50;
                    mb_done_i = 0;
                end
            end
            mem_gnt_i = 0;
            mem_rvalid_i = 0;
            if (mem_req_o) chk("single_outstanding", pending, 0);
            if (pending) begin
                if (rv_cnt == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i = mem_word(paddr);
                    pending = 0;
                end else rv_cnt--;
            end else begin
                if (spur && $urandom_range(0, 2) == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i = $urandom;
                end
                if (mem_req_o) begin
                    if (held) chk("addr_stable", mem_addr_o, prev_addr);
                    else gnt_cnt = $urandom_range(0, gnt_max);
                    if (gnt_cnt == 0) begin
                        ea = BASE + req_idx;
                        chk("req_addr", mem_addr_o, ea);
                        chk("req_x", mb_x_o, (req_idx / WPM) % W);
                        chk("req_y", mb_y_o, (req_idx / WPM) / W);
                        req_idx++;
                        mem_gnt_i = 1;
                        pending = 1;
                        paddr = mem_addr_o;
                        rv_cnt = $urandom_range(1, rv_max) - 1;
                    end else gnt_cnt--;
                end else if (spur) mem_gnt_i = 1'($urandom_range(0, 1));
            end
            held = mem_req_o && !mem_gnt_i;
            prev_addr = mem_addr_o;
        end
    end

    task automatic pulse_start();
        frame_start_i = 1;
        @(negedge clk);
        frame_start_i = 0;
    endtask

    task automatic wait_dv(input int n);
        int t = 0;
        while (dv_idx < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("dv_reached", dv_idx >= n, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (fd_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_seen", fd_cnt != 0, 1);
        @(negedge clk);
    endtask

    task automatic end_checks();
        chk("fs_count", fs_idx, W * H);
        chk("req_count", req_idx, TOTAL);
        chk("dv_count", dv_idx, TOTAL);
        chk("fd_count", fd_cnt, 1);
        chk("last_x", mb_x_o, W - 1);
        chk("last_y", mb_y_o, H - 1);
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs", {mem_req_o, busy_o, fetch_start_o, data_valid_o, frame_done_o,
                              mb_x_o, mb_y_o, data_word_o}, 0);
        end
        // frame 1: zero-wait memory, mb_done_i tied high
        pulse_start();
        chk("first_fs", fetch_start_o, 1);
        @(negedge clk);
        chk("first_req", mem_req_o, 1);
        chk("first_addr", mem_addr_o, BASE);
        wait_done();
        end_checks();
        // frame 2: random latencies, spurious inputs, mb_done held off, mid-frame start ignored
        fast = 0; gnt_max = 5; rv_max = 5; spur = 1; md_mode = 1;
        pulse_start();
        wait_dv(100);
        pulse_start();
        wait_done();
        end_checks();
        // frame 3: reset aborts macroblock (1,0) at word 40
        md_mode = 0;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_dv(WPM + 40);
        chk("pre_rst_x", mb_x_o, 1);
        chk("pre_rst_y", mb_y_o, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_outs", {mem_req_o, busy_o, fetch_start_o, data_valid_o, frame_done_o,
                         mb_x_o, mb_y_o, data_word_o}, 0);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {mem_req_o, data_valid_o, frame_done_o}, 0);
        end
        chk("no_done_after_abort", fd_cnt, 0);
        // frame 4: clean restart from (0,0) at BASE
        fast = 1; gnt_max = 0; rv_max = 1; spur = 0;
        pulse_start();
        chk("restart_fs", fetch_start_o, 1);
        @(negedge clk);
        chk("restart_addr", mem_addr_o, BASE);
        wait_done();
        end_checks();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
